// File: rtl/reg_ring_initiator.sv
`default_nettype none
// ============================================================================
// Module      : reg_ring_initiator
// Description : Register-ring master at the head of the UDP register ring.
//               Converts one host register access at a time into a request
//               token, waits for the token to come back around the ring and
//               returns read data plus an error flag to the host. The
//               initiator terminates the ring: returning tokens are consumed,
//               never forwarded.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk                  sole clock
//   reset                synchronous, active-low reset
//   core_reg_*           host side: level request held until one-cycle ack,
//                        read data and error valid with ack and held after
//   reg_*_out            ring request token, driven for exactly one cycle
//   reg_*_in             token returning from the end of the ring
// ----------------------------------------------------------------------------
// Configuration
//   REG_RING_INITIATOR_TIMEOUT_EN  defined: 16-bit watchdog aborts requests
//                                  that do not return within TIMEOUT clocks.
//                                  undefined: WAIT exits only on a response.
// ============================================================================

`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

module reg_ring_initiator #(
    parameter int                                UDP_REG_SRC_WIDTH = 2,
    parameter logic [UDP_REG_SRC_WIDTH-1:0]      SRC_ID            = '0,
    parameter int                                TIMEOUT           = 255,
    parameter logic [`CPCI_NF2_DATA_WIDTH-1:0]   NOACK_DATA        = 32'hDEAD_BEEF
) (
    input  logic                                 clk,
    input  logic                                 reset,

    input  logic                                 core_reg_req,
    input  logic                                 core_reg_rd_wr_L,
    input  logic [`UDP_REG_ADDR_WIDTH-1:0]       core_reg_addr,
    input  logic [`CPCI_NF2_DATA_WIDTH-1:0]      core_reg_wr_data,
    output logic                                 core_reg_ack,
    output logic [`CPCI_NF2_DATA_WIDTH-1:0]      core_reg_rd_data,
    output logic                                 core_reg_err,

    output logic                                 reg_req_out,
    output logic                                 reg_ack_out,
    output logic                                 reg_rd_wr_L_out,
    output logic [`UDP_REG_ADDR_WIDTH-1:0]       reg_addr_out,
    output logic [`CPCI_NF2_DATA_WIDTH-1:0]      reg_data_out,
    output logic [UDP_REG_SRC_WIDTH-1:0]         reg_src_out,

    input  logic                                 reg_req_in,
    input  logic                                 reg_ack_in,
    input  logic                                 reg_rd_wr_L_in,
    input  logic [`UDP_REG_ADDR_WIDTH-1:0]       reg_addr_in,
    input  logic [`CPCI_NF2_DATA_WIDTH-1:0]      reg_data_in,
    input  logic [UDP_REG_SRC_WIDTH-1:0]         reg_src_in
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t r_state;
    logic   r_rd_wr_L;   // direction of the outstanding request
    logic   r_blocked;   // set at completion, cleared once core_reg_req is seen low

`ifdef REG_RING_INITIATOR_TIMEOUT_EN
    localparam logic [15:0] c_TO_LAST = 16'(TIMEOUT - 1);
    logic [15:0] r_wd_cnt;
`else
    logic [31:0] w_unused_timeout;
    assign w_unused_timeout = TIMEOUT;
`endif

    // The returning token's address and direction are not needed: the
    // initiator has only one request in flight and matches on source tag.
    logic w_unused_ring;
    assign w_unused_ring = ^{reg_addr_in, reg_rd_wr_L_in};

    logic w_resp;
    assign w_resp = reg_req_in && (reg_src_in == SRC_ID);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state          <= IDLE;
            r_rd_wr_L        <= 1'b0;
            r_blocked        <= 1'b0;
            core_reg_ack     <= 1'b0;
            core_reg_rd_data <= '0;
            core_reg_err     <= 1'b0;
            reg_req_out      <= 1'b0;
            reg_ack_out      <= 1'b0;
            reg_rd_wr_L_out  <= 1'b0;
            reg_addr_out     <= '0;
            reg_data_out     <= '0;
            reg_src_out      <= '0;
`ifdef REG_RING_INITIATOR_TIMEOUT_EN
            r_wd_cnt         <= '0;
`endif
        end else begin
            // Unblock as soon as the host is seen idle; a completion in the
            // same cycle (below) re-arms the block and takes precedence.
            if (!core_reg_req) begin
                r_blocked <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (core_reg_req && !r_blocked) begin
                        // Ring output registers double as the latched request.
                        r_rd_wr_L       <= core_reg_rd_wr_L;
                        reg_req_out     <= 1'b1;
                        reg_ack_out     <= 1'b0;
                        reg_rd_wr_L_out <= core_reg_rd_wr_L;
                        reg_addr_out    <= core_reg_addr;
                        reg_data_out    <= core_reg_rd_wr_L ? '0 : core_reg_wr_data;
                        reg_src_out     <= SRC_ID;
                        r_state         <= ISSUE;
                    end
                end

                ISSUE: begin
                    reg_req_out     <= 1'b0;
                    reg_ack_out     <= 1'b0;
                    reg_rd_wr_L_out <= 1'b0;
                    reg_addr_out    <= '0;
                    reg_data_out    <= '0;
                    reg_src_out     <= '0;
`ifdef REG_RING_INITIATOR_TIMEOUT_EN
                    r_wd_cnt        <= '0;
`endif
                    r_state         <= WAIT;
                end

                WAIT: begin
                    // A response takes priority over a coincident timeout.
                    if (w_resp) begin
                        if (r_rd_wr_L) begin
                            core_reg_rd_data <= reg_ack_in ? reg_data_in : NOACK_DATA;
                        end else begin
                            core_reg_rd_data <= '0;
                        end
                        core_reg_err <= !reg_ack_in;
                        core_reg_ack <= 1'b1;
                        r_blocked    <= 1'b1;
                        r_state      <= DONE;
                    end
`ifdef REG_RING_INITIATOR_TIMEOUT_EN
                    else if (r_wd_cnt == c_TO_LAST) begin
                        core_reg_rd_data <= r_rd_wr_L ? NOACK_DATA : '0;
                        core_reg_err     <= 1'b1;
                        core_reg_ack     <= 1'b1;
                        r_blocked        <= 1'b1;
                        r_state          <= DONE;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 16'd1;
                    end
`endif
                end

                DONE: begin
                    core_reg_ack <= 1'b0;
                    r_state      <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
